aes_column_mix: RTL and testbench

AES MixColumns / InvMixColumns round stage with a start/ready handshake. It accepts a 128-bit AES state and transforms each of the four columns by the fixed GF(2^8) matrix: forward for encryption, inverse for decryption. It processes one column per clock and presents the full result with a one-cycle ready pulse. It sits in the AES round datapath after ShiftRows (encrypt) or after AddRoundKey (decrypt).

---
 rtl/aes_column_mix.sv | 188 ++++++++++++++++++
 tb/tb_aes_column_mix.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_column_mix.sv
// Purpose : AES MixColumns (en_de=1) / InvMixColumns (en_de=0) over a 128-bit state, one column per clock.
// Latency : 4 cycles from the accepting start edge to the ready_out pulse; next start accepted one cycle later.
// Backpres: none; start_in is ignored while busy, and the result is held in data_out until the next completion.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (clears all state and outputs)
//   data_in   AES state, row-major: byte(r,c) = data_in[127-8*(4r+c) -: 8]
//   start_in  start request, sampled on the rising edge while idle
//   en_de     1 = forward MixColumns, 0 = InvMixColumns (captured with data_in)
//   data_out  transformed state, same byte layout, updated only at completion
//   ready_out one-cycle pulse coincident with a new data_out

module aes_column_mix (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] data_in,
  input  logic         start_in,
  input  logic         en_de,
  output logic [127:0] data_out,
  output logic         ready_out
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // One column as {a0, a1, a2, a3}, a0 in the top byte (row 0).
  typedef logic [31:0] col_t;

  // GF(2^8) doubling modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // Forward or inverse matrix applied to a single column. All constant
  // multipliers are derived from the x2/x4/x8 chain so only three xtime
  // stages per byte are needed regardless of mode.
  function automatic col_t mix_column(input col_t col, input logic fwd);
    logic [7:0] a  [4];
    logic [7:0] m2 [4];
    logic [7:0] m3 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x4;
    logic [7:0] x8;
    col_t       res;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      m2[i] = xtime(a[i]);
      x4    = xtime(m2[i]);
      x8    = xtime(x4);
      m3[i] = m2[i] ^ a[i];
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ m2[i] ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ m2[i];
    end
    if (fwd) begin
      res[31:24] = m2[0] ^ m3[1] ^ a[2]  ^ a[3];
      res[23:16] = a[0]  ^ m2[1] ^ m3[2] ^ a[3];
      res[15:8]  = a[0]  ^ a[1]  ^ m2[2] ^ m3[3];
      res[7:0]   = m3[0] ^ a[1]  ^ a[2]  ^ m2[3];
    end else begin
      res[31:24] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      res[23:16] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      res[15:8]  = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      res[7:0]   = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
    return res;
  endfunction

  state_e       state_q;
  state_e       state_d;
  logic [1:0]   col_q;
  logic [127:0] blk_q;    // state captured at the start edge
  logic         mode_q;   // en_de captured at the start edge
  logic [127:0] work_q;   // columns finished so far

  logic         capture;
  logic         step;
  logic         finish;

  col_t         cols [4];
  col_t         col_in;
  col_t         col_out;
  logic [127:0] merged;

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_in)      state_d = BUSY;
      BUSY:    if (col_q == 2'd3) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // FSM: control outputs
  // ---------------------------------------------------------------
  always_comb begin
    capture = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: capture = start_in;
      BUSY: begin
        step   = 1'b1;
        finish = (col_q == 2'd3);
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------
  // Datapath: column gather, transform, scatter
  // ---------------------------------------------------------------
  // Regroup the row-major captured state into columns using constant
  // indices only, so the active column is a plain 4:1 select.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      cols[c] = '0;
      for (int r = 0; r < 4; r++) begin
        cols[c][31-8*r -: 8] = blk_q[127-8*(4*r+c) -: 8];
      end
    end
  end

  assign col_in  = cols[col_q];
  assign col_out = mix_column(col_in, mode_q);

  // Working register with the current column replaced by the fresh result.
  // On the final column this is the complete output block, which avoids a
  // separate assembly step and keeps data_out free of partial results.
  always_comb begin
    merged = work_q;
    for (int c = 0; c < 4; c++) begin
      if (c == int'(col_q)) begin
        for (int r = 0; r < 4; r++) begin
          merged[127-8*(4*r+c) -: 8] = col_out[31-8*r -: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= 2'd0;
      blk_q     <= '0;
      mode_q    <= 1'b0;
      work_q    <= '0;
      data_out  <= '0;
      ready_out <= 1'b0;
    end else begin
      ready_out <= finish;
      if (capture) begin
        blk_q  <= data_in;
        mode_q <= en_de;
        col_q  <= 2'd0;
      end
      if (step) begin
        work_q <= merged;
        col_q  <= col_q + 2'd1;   // wraps to 0 after the last column
      end
      if (finish) begin
        data_out <= merged;
      end
    end
  end

endmodule

// File: tb/tb_aes_column_mix.sv
module tb_aes_column_mix;

  localparam logic [127:0] FIPS_IN  = 128'hd4e0b81e_bfb44127_5d521198_30aef1e5;
  localparam logic [127:0] FIPS_OUT = 128'h04e04828_66cbf806_8119d326_e59a7a4c;
  localparam logic [127:0] DB_IN    = 128'hdbdbdbdb_13131313_53535353_45454545;
  localparam logic [127:0] DB_OUT   = 128'h8e8e8e8e_4d4d4d4d_a1a1a1a1_bcbcbcbc;
  localparam logic [127:0] C6_ALL   = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;
  localparam logic [127:0] JUNK     = 128'h01234567_89abcdef_fedcba98_76543210;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [127:0] data_in = '0;
  logic         start_in = 1'b0;
  logic         en_de = 1'b0;
  logic [127:0] data_out;
  logic         ready_out;

  aes_column_mix dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .start_in  (start_in),
    .en_de     (en_de),
    .data_out  (data_out),
    .ready_out (ready_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expected block and the cycle count at which it must appear.
  logic [127:0] exp_q     [$];
  int           exp_cyc_q [$];

  int n_vec = 0;
  int n_bad = 0;

  logic [127:0] last_exp = '0;
  logic [127:0] mon_exp;
  int           mon_cyc;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the head of the scoreboard, both in
  // data and in the cycle it arrives; a pulse with nothing expected is an error.
  always @(negedge clk) begin
    if (ready_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_ready: got pulse at cycle %0d data_out=%h, expected none", cyc, data_out);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        check("result", data_out, mon_exp);
        check_int("ready_latency", cyc, mon_cyc);
      end
    end
  end

  // Issue one start pulse; called just after a falling edge.
  task automatic run_op(input logic [127:0] d, input logic mode, input logic [127:0] exp);
    @(negedge clk);
    data_in  = d;
    en_de    = mode;
    start_in = 1'b1;
    exp_q.push_back(exp);
    exp_cyc_q.push_back(cyc + 5);
    last_exp = exp;
    @(negedge clk);
    start_in = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge clk);
    check_int("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset before any clock edge.
    #3 rst_n = 1'b0;
    #1;
    check("reset_data_out", data_out, '0);
    check("reset_ready", {127'b0, ready_out}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("idle_data_out", data_out, '0);

    // Forward, FIPS-197 round 1, then hold check.
    run_op(FIPS_IN, 1'b1, FIPS_OUT);
    wait_drain();
    repeat (3) @(negedge clk);
    check("hold_after_ready", data_out, last_exp);

    // Inverse of the same vector.
    run_op(FIPS_OUT, 1'b0, FIPS_IN);
    wait_drain();

    // Equal-column vectors in both directions.
    run_op(DB_IN, 1'b1, DB_OUT);
    wait_drain();
    run_op(DB_OUT, 1'b0, DB_IN);
    wait_drain();
    run_op(C6_ALL, 1'b1, C6_ALL);
    wait_drain();
    run_op(C6_ALL, 1'b0, C6_ALL);
    wait_drain();

    // Start re-asserted while busy, including on the completing edge, with
    // inputs changed: only the first captured request may complete.
    @(negedge clk);
    data_in  = FIPS_IN;
    en_de    = 1'b1;
    start_in = 1'b1;
    exp_q.push_back(FIPS_OUT);
    exp_cyc_q.push_back(cyc + 5);
    last_exp = FIPS_OUT;
    @(negedge clk);               // after edge N
    start_in = 1'b0;
    data_in  = JUNK;
    en_de    = 1'b0;
    @(negedge clk);               // after N+1
    start_in = 1'b1;
    @(negedge clk);               // after N+2
    start_in = 1'b0;
    @(negedge clk);               // after N+3
    start_in = 1'b1;
    @(negedge clk);               // after N+4 (completing edge)
    start_in = 1'b0;
    wait_drain();
    repeat (8) @(negedge clk);
    check("busy_start_ignored", data_out, FIPS_OUT);

    // start_in held high: a new operation every 5 cycles.
    @(negedge clk);
    data_in  = DB_IN;
    en_de    = 1'b1;
    start_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(DB_OUT);
      exp_cyc_q.push_back(cyc + 5 + 5 * k);
    end
    repeat (15) @(posedge clk);
    @(negedge clk);
    start_in = 1'b0;
    wait_drain();
    repeat (8) @(negedge clk);

    // Reset two edges into an operation: no pulse, outputs cleared.
    @(negedge clk);
    data_in  = FIPS_IN;
    en_de    = 1'b1;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    @(posedge clk);               // N+1
    @(posedge clk);               // N+2
    #1 rst_n = 1'b0;
    #1;
    check("midop_reset_data_out", data_out, '0);
    check("midop_reset_ready", {127'b0, ready_out}, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_abort_data_out", data_out, '0);

    run_op(FIPS_IN, 1'b1, FIPS_OUT);
    wait_drain();
    check("after_abort_result", data_out, FIPS_OUT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
